// File: rtl/outreg_pkg.sv
// outreg_pkg: shared matrix geometry and FSM encoding for the output register arbiter
package outreg_pkg;
  localparam int MAT_W = 256;
  localparam int ELEM_W = 16;
  localparam int MAT_DIM = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } state_t;
endpackage

// File: rtl/output_reg_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from rr_ptr+1 with wrap
module rr_arbiter
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W = $clog2(NUM_REQ)
)
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               grant_valid
);
  import outreg_pkg::*;
  logic [IDX_W-1:0] idx;
  // Walk from the farthest offset down so the nearest set bit is the one that sticks.
  always_comb begin
    grant = '0;
    idx = '0;
    grant_valid = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[idx]) grant = idx;
    end
  end
endmodule

// File: rtl/output_reg_arbiter.sv
// output_reg_arbiter: round-robin sharing of the matrix output register (write, settle, ack).
// Define OUTREG_ARB_VERIFY_EN to compare readback against the written matrix in ACK.
module output_reg_arbiter
#(
  parameter int NUM_REQ = 3,
  parameter int MAT_W = outreg_pkg::MAT_W,
  parameter int IDX_W = $clog2(NUM_REQ)
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MAT_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     reg_write_data,
  output logic [MAT_W-1:0]         reg_data_to_write,
  input  logic [MAT_W-1:0]         reg_data_in,
  output logic                     busy,
  output logic [IDX_W-1:0]         owner,
  output logic                     verify_err
);
  import outreg_pkg::*;
  state_t state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, grant;
  logic [MAT_W-1:0] hold_q, hold_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic write_q, write_d, busy_q, busy_d, verr_q, verr_d, grant_valid, take;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req(req),
    .rr_ptr(rr_ptr_q),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (grant_valid ? WRITE : IDLE) :
              (state_q == WRITE) ? SETTLE :
              (state_q == SETTLE) ? ACK : IDLE;
  end
  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    take = (state_q == IDLE) && grant_valid;
    owner_d = take ? grant : owner_q;
    hold_d = take ? req_data[grant*MAT_W +: MAT_W] : hold_q;
    rr_ptr_d = (state_q == ACK) ? owner_q : rr_ptr_q;
    write_d = state_d == WRITE;
    busy_d = state_d != IDLE;
    ack_d = (state_d == ACK) ? NUM_REQ'(1) << owner_q : '0;
`ifdef OUTREG_ARB_VERIFY_EN
    verr_d = verr_q | ((state_q == ACK) && (reg_data_in != hold_q));
`else
    verr_d = 1'b0;
`endif
  end
`ifndef OUTREG_ARB_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^reg_data_in;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      hold_q <= '0;
      ack_q <= '0;
      write_q <= 1'b0;
      busy_q <= 1'b0;
      verr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      hold_q <= hold_d;
      ack_q <= ack_d;
      write_q <= write_d;
      busy_q <= busy_d;
      verr_q <= verr_d;
    end
  end
  assign ack = ack_q;
  assign reg_write_data = write_q;
  assign reg_data_to_write = hold_q;
  assign busy = busy_q;
  assign owner = owner_q;
  assign verify_err = verr_q;
endmodule

// File: tb/tb_output_reg_arbiter.sv
// tb_output_reg_arbiter: scoreboard bench with a transaction-level round-robin model
module tb_output_reg_arbiter;
  localparam int N = 3;
  localparam int W = 256;
`ifdef OUTREG_ARB_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  typedef struct {
    int w;
    logic [W-1:0] d;
    int wr_cyc;
    int ack_cyc;
  } txn_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] ack;
  logic reg_write_data;
  logic [W-1:0] reg_data_to_write, reg_data_in, stored;
  logic busy, verify_err;
  logic [1:0] owner;
  logic corrupt = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rem = 0;
  int last = N - 1;
  bit busy_exp = 1'b0;
  bit rst_seen = 1'b1;
  bit exp_verr = 1'b0;
  txn_t q[$];
  int order_log[$];
  output_reg_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .reg_write_data(reg_write_data),
    .reg_data_to_write(reg_data_to_write),
    .reg_data_in(reg_data_in),
    .busy(busy),
    .owner(owner),
    .verify_err(verify_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (reg_write_data) stored <= reg_data_to_write;
  assign reg_data_in = corrupt ? '0 : stored;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference model: one transaction at a time, four cycles each, round-robin after the last winner.
  always @(posedge clk) begin
    rst_seen = reset;
    if (reset) begin
      q.delete();
      rem = 0;
      last = N - 1;
    end else if (rem == 0 && req != 0) begin
      for (int i = 1; i <= N; i++) begin
        if (req[(last + i) % N]) begin
          last = (last + i) % N;
          break;
        end
      end
      q.push_back('{last, req_data[last*W +: W], cyc + 1, cyc + 3});
      rem = 3;
    end else if (rem > 0) rem--;
    busy_exp = rem > 0;
    cyc++;
  end
  always @(negedge clk) begin
    if (rst_seen) begin
      exp_verr = 1'b0;
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_write", reg_write_data, 0);
      chk("rst_wdata", reg_data_to_write, 0);
      chk("rst_verr", verify_err, 0);
    end else begin
      chk("busy", busy, busy_exp);
      chk("verify_err", verify_err, exp_verr);
      if (reg_write_data) begin
        if (q.size() == 0) chk("spurious_write", reg_write_data, 0);
        else begin
          chk("write_cycle", cyc, q[0].wr_cyc);
          chk("write_data", reg_data_to_write, q[0].d);
          chk("owner_at_write", owner, q[0].w);
        end
      end
      if (ack != 0) begin
        if (q.size() == 0) chk("spurious_ack", ack, 0);
        else begin
          chk("ack_vec", ack, 1 << q[0].w);
          chk("ack_owner", owner, q[0].w);
          chk("ack_cycle", cyc, q[0].ack_cyc);
          if (VER && reg_data_in != q[0].d) exp_verr = 1'b1;
          order_log.push_back(int'(owner));
          q.pop_front();
        end
      end else if (q.size() != 0 && cyc == q[0].ack_cyc) begin
        chk("ack_missing", ack, 1 << q[0].w);
        q.pop_front();
      end
    end
  end
  function automatic logic [W-1:0] rand_mat();
    logic [W-1:0] m;
    for (int i = 0; i < W / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction
  task automatic step();
    @(negedge clk);
    req = req & ~ack;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while ((req != 0 || q.size() != 0 || busy_exp) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", req, 0);
  endtask
  task automatic wait_write(input int budget);
    int n = 0;
    while (!reg_write_data && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("write_timeout", reg_write_data, 1);
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  initial begin
    logic [W-1:0] d0;
    int exp_ord[3];
    repeat (3) step();
    reset = 1'b0;
    for (int e = 0; e < 16; e++) d0[(15 - e)*16 +: 16] = 16'(e + 1);
    req_data[0 +: W] = d0;
    req = 3'b001;
    drain(40);
    chk("readback", reg_data_in, d0);
    pulse_reset();
    order_log.delete();
    for (int k = 0; k < N; k++) req_data[k*W +: W] = rand_mat();
    req = 3'b111;
    drain(60);
    exp_ord = '{0, 1, 2};
    chk("order_len", order_log.size(), 3);
    for (int i = 0; i < 3 && i < order_log.size(); i++) chk("rr_order", order_log[i], exp_ord[i]);
    order_log.delete();
    req_data[0 +: W] = rand_mat();
    req_data[2*W +: W] = rand_mat();
    req = 3'b101;
    drain(60);
    chk("wrap_len", order_log.size(), 2);
    if (order_log.size() == 2) begin
      chk("wrap_first", order_log[0], 0);
      chk("wrap_second", order_log[1], 2);
    end
    req_data[W +: W] = rand_mat();
    req = 3'b010;
    wait_write(20);
    step();
    req[1] = 1'b0;
    drain(20);
    req_data[2*W +: W] = rand_mat();
    req = 3'b100;
    wait_write(20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drain(40);
    corrupt = 1'b1;
    req_data[0 +: W] = '1;
    req = 3'b001;
    drain(40);
    corrupt = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(3) == 0) begin
          req_data[k*W +: W] = rand_mat();
          req[k] = 1'b1;
        end
      end
    end
    drain(100);
    chk("queue_empty", q.size(), 0);
    pulse_reset();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/output_reg_arbiter.md
Name: output_reg_arbiter

Overview:
Shares the single 256-bit output register (one 4x4 matrix of 16-bit elements) between several result producers, e.g. ALU, matrix multiplier and memory copy path. Each requester holds a level request with its matrix. The block arbitrates round-robin, sequences the register's write and read phases, and returns a one-cycle ack to the winner. It sits between the execution units and the output register.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAT_W, 256, matrix width in bits (16 elements x 16 bits)
IDX_W, $clog2(NUM_REQ), width of owner index

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  level request per requester
req_data  input  NUM_REQ*MAT_W  flattened matrices; requester k at bits [k*MAT_W +: MAT_W]
ack  output  NUM_REQ  one-hot, one-cycle completion pulse
reg_write_data  output  1  drives output register write_data (1 = write, 0 = read)
reg_data_to_write  output  MAT_W  drives output register data_to_write
reg_data_in  input  MAT_W  output register data (readback)
busy  output  1  high in any state except IDLE
owner  output  IDX_W  index of current or last granted requester
verify_err  output  1  sticky readback mismatch flag (see Optional Feature)

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: ack=0, reg_write_data=0, reg_data_to_write=0, busy=0, owner=0, verify_err=0, state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, WRITE, SETTLE, ACK.
- All outputs are registered.
- IDLE: if req!=0, grant the first set bit searching upward from rr_ptr+1 with wrap. Capture req_data[grant] into a hold register, set owner=grant, go WRITE. If req==0, stay.
- WRITE: reg_write_data=1 for exactly one cycle, reg_data_to_write=hold. Then go SETTLE.
- SETTLE: reg_write_data=0, so the output register returns to read mode and presents its contents. reg_data_to_write keeps hold. Then go ACK.
- ACK: ack[owner]=1 for one cycle, rr_ptr<=owner, then go IDLE.
- Latency: req sampled in IDLE at cycle 0 gives reg_write_data high in cycle 1 and ack high in cycle 3. Minimum 4 cycles per transaction.
- Handshake: the requester holds req and req_data stable until it samples ack=1, then drops req on that same edge. Data is captured only in IDLE.
- Dropping req after the grant does not cancel the transaction: the write completes and ack still pulses.
- Simultaneous requests: exactly one grant per transaction, round-robin.
- Requester starvation is bounded to NUM_REQ-1 transactions.
- Requests arriving while busy wait; nothing is queued beyond the req level.
- Reset mid-transaction: return to IDLE next edge, no ack is issued, reg_write_data=0. A write already committed stays in the register unless the register's own reset clears it.
- req bits at positions >= NUM_REQ do not exist; unset req bits never produce an ack.

Optional Feature:
Macro OUTREG_ARB_VERIFY_EN.
- Defined: in ACK, compare reg_data_in with hold. On mismatch set verify_err=1, sticky until reset. ack is issued regardless.
- Undefined: no compare logic; verify_err is tied 0 and the port remains present.

Decomposition:
- Package outreg_pkg: MAT_W=256, ELEM_W=16, MAT_DIM=4, FSM state encoding (IDLE=0, WRITE=1, SETTLE=2, ACK=3).
- Sub-module rr_arbiter: inputs req and rr_ptr; outputs grant index and grant_valid. Purely combinational priority rotation, instantiated once.

Test Plan:
- Reset, then req=3'b001 with data 256'h0001_0002_..._0010 -> reg_write_data high exactly cycle 1, ack=3'b001 in cycle 3, readback equals data, verify_err=0.
- req=3'b111 held, each requester dropping on its own ack -> grant order 0,1,2; three acks 4 cycles apart; owner sequence 0,1,2.
- After granting 2, req=3'b101 -> next grant 0, then 2; rr_ptr wraps correctly.
- Requester 1 drops req in SETTLE -> ack[1] still pulses in cycle 3; no second write.
- Reset asserted in WRITE cycle -> next cycle state IDLE, ack=0, busy=0, owner=0, reg_write_data=0.
- With OUTREG_ARB_VERIFY_EN, force reg_data_in=0 for a write of 256'hFFFF...FFFF -> verify_err=1 after ACK, stays 1 through later transactions until reset.
